bcd_to_bin_seq: RTL

//   Sequential BCD-to-binary converter for decimal entry from SW/KEY into the arithmetic datapath.
//   It is the inverse of the bin-to-BCD display path.

---
 rtl/bcd_to_bin_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/bcd_to_bin_seq.sv
// ============================================================================
// Module      : bcd_to_bin_seq
// Description : Sequential packed-BCD to binary converter, MSD first, one digit
//               per clock (acc = acc*10 + digit), start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_bin_seq #(
    parameter int N_DIGITS = 5,
    parameter int W_BIN    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [4*N_DIGITS-1:0]   i_bcd,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [W_BIN-1:0]        o_bin,
    output logic                    o_invalid,
    output logic                    o_overflow
);

    localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int AW = W_BIN + 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] C_LAST = CW'(N_DIGITS - 1);
    localparam logic [AW-1:0] C_MAX  = {4'b0000, {W_BIN{1'b1}}};

    logic [1:0]            r_state;
    logic [4*N_DIGITS-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic [W_BIN-1:0]      r_acc;
    logic                  r_inv;
    logic                  r_ovf;

    logic [3:0]            w_digit;
    logic [AW-1:0]         w_acc_ext;
    logic [AW-1:0]         w_sum;
    logic                  w_big;
    logic [W_BIN-1:0]      w_acc_next;
    logic                  w_inv_next;
    logic                  w_ovf_next;
    logic                  w_last;

    // acc*10 as (acc<<3)+(acc<<1); AW bits hold 10*(2^W_BIN-1)+15 without wrap
    always_comb begin
        w_digit    = r_shift[4*N_DIGITS-1 -: 4];
        w_acc_ext  = {4'b0000, r_acc};
        w_sum      = (w_acc_ext << 3) + (w_acc_ext << 1) + {{W_BIN{1'b0}}, w_digit};
        w_big      = (w_sum > C_MAX);
        w_acc_next = w_big ? {W_BIN{1'b1}} : w_sum[W_BIN-1:0];
        w_inv_next = r_inv | (w_digit > 4'd9);
        w_ovf_next = r_ovf | w_big;
        w_last     = (r_cnt == C_LAST);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_inv      <= 1'b0;
            r_ovf      <= 1'b0;
            o_bin      <= '0;
            o_invalid  <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_shift <= i_bcd;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_inv   <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shift <= r_shift << 4;
                    r_cnt   <= r_cnt + 1'b1;
                    r_acc   <= w_acc_next;
                    r_inv   <= w_inv_next;
                    r_ovf   <= w_ovf_next;
                    if (w_last) begin
                        // invalid digits dominate overflow in the reported result
                        o_bin      <= w_inv_next ? '0 :
                                      (w_ovf_next ? {W_BIN{1'b1}} : w_acc_next);
                        o_invalid  <= w_inv_next;
                        o_overflow <= w_ovf_next & ~w_inv_next;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (r_state == S_CONV) || (r_state == S_DONE);
    assign o_done = (r_state == S_DONE);

endmodule

`default_nettype wire
